// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: merges ALU and LSB results onto one registered CDB.
// Each source has a result FIFO; round-robin grant with an empty-FIFO bypass.
module cdb_arbiter #(
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         mispredict,
  input  logic                         alu_valid,
  input  logic [ROB_ID_W-1:0]          alu_rob_id,
  input  logic [DATA_W-1:0]            alu_value,
  input  logic                         alu_jump,
  input  logic [ADDR_W-1:0]            alu_pc_next,
  output logic                         alu_ready,
  input  logic                         lsb_valid,
  input  logic [ROB_ID_W-1:0]          lsb_rob_id,
  input  logic [DATA_W-1:0]            lsb_value,
  output logic                         lsb_ready,
  output logic                         cdb_valid,
  output logic [ROB_ID_W-1:0]          cdb_rob_id,
  output logic [DATA_W-1:0]            cdb_value,
  output logic                         cdb_jump,
  output logic [ADDR_W-1:0]            cdb_pc_next,
  output logic                         cdb_src,
  output logic [$clog2(DEPTH+1)-1:0]   alu_count,
  output logic [$clog2(DEPTH+1)-1:0]   lsb_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  // FIFO storage
  logic [ROB_ID_W-1:0] alu_id_mem  [DEPTH];
  logic [DATA_W-1:0]   alu_val_mem [DEPTH];
  logic                alu_jmp_mem [DEPTH];
  logic [ADDR_W-1:0]   alu_pc_mem  [DEPTH];
  logic [ROB_ID_W-1:0] lsb_id_mem  [DEPTH];
  logic [DATA_W-1:0]   lsb_val_mem [DEPTH];

  logic [PTR_W-1:0] alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [PTR_W-1:0] lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  src_e             last_q, last_d;

  logic                cdb_valid_q, cdb_valid_d;
  logic [ROB_ID_W-1:0] cdb_id_q, cdb_id_d;
  logic [DATA_W-1:0]   cdb_val_q, cdb_val_d;
  logic                cdb_jump_q, cdb_jump_d;
  logic [ADDR_W-1:0]   cdb_pc_q, cdb_pc_d;
  src_e                cdb_src_q, cdb_src_d;

  logic flush;
  logic alu_hs, lsb_hs;
  logic alu_empty, lsb_empty;
  logic alu_req, lsb_req;
  logic grant_alu, grant_lsb;
  logic alu_push, alu_pop, lsb_push, lsb_pop;

  assign flush     = rdy && mispredict;
  assign alu_ready = rdy && (alu_cnt_q < FULL_CNT);
  assign lsb_ready = rdy && (lsb_cnt_q < FULL_CNT);
  assign alu_hs    = alu_valid && alu_ready;
  assign lsb_hs    = lsb_valid && lsb_ready;
  assign alu_empty = (alu_cnt_q == '0);
  assign lsb_empty = (lsb_cnt_q == '0);
  assign alu_req   = !alu_empty || alu_hs;
  assign lsb_req   = !lsb_empty || lsb_hs;

  always_comb begin
    grant_alu = 1'b0;
    grant_lsb = 1'b0;
    if (rdy && !mispredict) begin
      if (alu_req && lsb_req) begin
        if (last_q == SRC_ALU) grant_lsb = 1'b1;
        else                   grant_alu = 1'b1;
      end else begin
        grant_alu = alu_req;
        grant_lsb = lsb_req;
      end
    end
  end

  // An empty winner bypasses its FIFO, so its handshake is not a push.
  assign alu_pop  = grant_alu && !alu_empty;
  assign lsb_pop  = grant_lsb && !lsb_empty;
  assign alu_push = alu_hs && !flush && !(grant_alu && alu_empty);
  assign lsb_push = lsb_hs && !flush && !(grant_lsb && lsb_empty);

  always_comb begin
    alu_wr_d    = alu_wr_q;
    alu_rd_d    = alu_rd_q;
    alu_cnt_d   = alu_cnt_q;
    lsb_wr_d    = lsb_wr_q;
    lsb_rd_d    = lsb_rd_q;
    lsb_cnt_d   = lsb_cnt_q;
    last_d      = last_q;
    cdb_valid_d = cdb_valid_q;
    cdb_id_d    = cdb_id_q;
    cdb_val_d   = cdb_val_q;
    cdb_jump_d  = cdb_jump_q;
    cdb_pc_d    = cdb_pc_q;
    cdb_src_d   = cdb_src_q;
    if (flush) begin
      alu_wr_d    = '0;
      alu_rd_d    = '0;
      alu_cnt_d   = '0;
      lsb_wr_d    = '0;
      lsb_rd_d    = '0;
      lsb_cnt_d   = '0;
      last_d      = SRC_LSB;
      cdb_valid_d = 1'b0;
    end else if (rdy) begin
      if (alu_push) alu_wr_d = alu_wr_q + PTR_W'(1);
      if (alu_pop)  alu_rd_d = alu_rd_q + PTR_W'(1);
      if (lsb_push) lsb_wr_d = lsb_wr_q + PTR_W'(1);
      if (lsb_pop)  lsb_rd_d = lsb_rd_q + PTR_W'(1);
      if (alu_push && !alu_pop)      alu_cnt_d = alu_cnt_q + CNT_W'(1);
      else if (alu_pop && !alu_push) alu_cnt_d = alu_cnt_q - CNT_W'(1);
      if (lsb_push && !lsb_pop)      lsb_cnt_d = lsb_cnt_q + CNT_W'(1);
      else if (lsb_pop && !lsb_push) lsb_cnt_d = lsb_cnt_q - CNT_W'(1);
      cdb_valid_d = grant_alu || grant_lsb;
      if (grant_alu) begin
        last_d    = SRC_ALU;
        cdb_src_d = SRC_ALU;
        if (alu_empty) begin
          cdb_id_d   = alu_rob_id;
          cdb_val_d  = alu_value;
          cdb_jump_d = alu_jump;
          cdb_pc_d   = alu_pc_next;
        end else begin
          cdb_id_d   = alu_id_mem[alu_rd_q];
          cdb_val_d  = alu_val_mem[alu_rd_q];
          cdb_jump_d = alu_jmp_mem[alu_rd_q];
          cdb_pc_d   = alu_pc_mem[alu_rd_q];
        end
      end else if (grant_lsb) begin
        last_d     = SRC_LSB;
        cdb_src_d  = SRC_LSB;
        cdb_jump_d = 1'b0;
        cdb_pc_d   = '0;
        if (lsb_empty) begin
          cdb_id_d  = lsb_rob_id;
          cdb_val_d = lsb_value;
        end else begin
          cdb_id_d  = lsb_id_mem[lsb_rd_q];
          cdb_val_d = lsb_val_mem[lsb_rd_q];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_wr_q    <= '0;
      alu_rd_q    <= '0;
      alu_cnt_q   <= '0;
      lsb_wr_q    <= '0;
      lsb_rd_q    <= '0;
      lsb_cnt_q   <= '0;
      last_q      <= SRC_LSB;
      cdb_valid_q <= 1'b0;
      cdb_id_q    <= '0;
      cdb_val_q   <= '0;
      cdb_jump_q  <= 1'b0;
      cdb_pc_q    <= '0;
      cdb_src_q   <= SRC_ALU;
    end else begin
      alu_wr_q    <= alu_wr_d;
      alu_rd_q    <= alu_rd_d;
      alu_cnt_q   <= alu_cnt_d;
      lsb_wr_q    <= lsb_wr_d;
      lsb_rd_q    <= lsb_rd_d;
      lsb_cnt_q   <= lsb_cnt_d;
      last_q      <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_id_q    <= cdb_id_d;
      cdb_val_q   <= cdb_val_d;
      cdb_jump_q  <= cdb_jump_d;
      cdb_pc_q    <= cdb_pc_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  // Storage needs no reset: entries are only read below a non-zero count.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_id_mem[alu_wr_q]  <= alu_rob_id;
      alu_val_mem[alu_wr_q] <= alu_value;
      alu_jmp_mem[alu_wr_q] <= alu_jump;
      alu_pc_mem[alu_wr_q]  <= alu_pc_next;
    end
    if (lsb_push) begin
      lsb_id_mem[lsb_wr_q]  <= lsb_rob_id;
      lsb_val_mem[lsb_wr_q] <= lsb_value;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_id  = cdb_id_q;
  assign cdb_value   = cdb_val_q;
  assign cdb_jump    = cdb_jump_q;
  assign cdb_pc_next = cdb_pc_q;
  assign cdb_src     = cdb_src_q;
  assign alu_count   = alu_cnt_q;
  assign lsb_count   = lsb_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-checked vectors plus a per-source
// queue model with its own round-robin grant.
module tb_cdb_arbiter;

  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = $clog2(DEPTH+1);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                rdy = 1'b1;
  logic                mispredict = 1'b0;
  logic                alu_valid = 1'b0;
  logic [ROB_ID_W-1:0] alu_rob_id = '0;
  logic [DATA_W-1:0]   alu_value = '0;
  logic                alu_jump = 1'b0;
  logic [ADDR_W-1:0]   alu_pc_next = '0;
  logic                alu_ready;
  logic                lsb_valid = 1'b0;
  logic [ROB_ID_W-1:0] lsb_rob_id = '0;
  logic [DATA_W-1:0]   lsb_value = '0;
  logic                lsb_ready;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [DATA_W-1:0]   cdb_value;
  logic                cdb_jump;
  logic [ADDR_W-1:0]   cdb_pc_next;
  logic                cdb_src;
  logic [CNT_W-1:0]    alu_count;
  logic [CNT_W-1:0]    lsb_count;

  cdb_arbiter #(
    .ROB_ID_W(ROB_ID_W),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .mispredict (mispredict),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_jump   (alu_jump),
    .alu_pc_next(alu_pc_next),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_ready  (lsb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_jump   (cdb_jump),
    .cdb_pc_next(cdb_pc_next),
    .cdb_src    (cdb_src),
    .alu_count  (alu_count),
    .lsb_count  (lsb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROB_ID_W-1:0] id;
    logic [DATA_W-1:0]   val;
    logic                jmp;
    logic [ADDR_W-1:0]   pc;
  } ent_t;

  ent_t aq[$];
  ent_t lq[$];
  int   errors = 0;
  int   checks = 0;

  logic                m_last = 1'b1;
  logic                e_valid = 1'b0;
  logic [ROB_ID_W-1:0] e_id = '0;
  logic [DATA_W-1:0]   e_val = '0;
  logic                e_jmp = 1'b0;
  logic [ADDR_W-1:0]   e_pc = '0;
  logic                e_src = 1'b0;

  logic [ROB_ID_W-1:0] a_id = '0;
  logic [DATA_W-1:0]   a_val = 32'hA000_0000;
  logic                a_jmp = 1'b0;
  logic [ADDR_W-1:0]   a_pc = 32'h0000_1000;
  logic [ROB_ID_W-1:0] l_id = '0;
  logic [DATA_W-1:0]   l_val = 32'hB000_0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    lq.delete();
    m_last  = 1'b1;
    e_valid = 1'b0;
    e_id    = '0;
    e_val   = '0;
    e_jmp   = 1'b0;
    e_pc    = '0;
    e_src   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    chk("cdb_rob_id", 64'(cdb_rob_id), 64'(e_id));
    chk("cdb_value", 64'(cdb_value), 64'(e_val));
    chk("cdb_jump", 64'(cdb_jump), 64'(e_jmp));
    chk("cdb_pc_next", 64'(cdb_pc_next), 64'(e_pc));
    chk("cdb_src", 64'(cdb_src), 64'(e_src));
    chk("alu_count", 64'(alu_count), 64'(aq.size()));
    chk("lsb_count", 64'(lsb_count), 64'(lq.size()));
    chk("alu_ready", 64'(alu_ready), 64'(rdy && aq.size() < DEPTH));
    chk("lsb_ready", 64'(lsb_ready), 64'(rdy && lq.size() < DEPTH));
  endtask

  // Drive one cycle, advance to just after the edge, update the model, check.
  task automatic step(input logic av, input logic lv);
    ent_t ea, el, e;
    logic acc_a, acc_l, ga, gl;
    ea = '{id: a_id, val: a_val, jmp: a_jmp, pc: a_pc};
    el = '{id: l_id, val: l_val, jmp: 1'b0, pc: '0};
    alu_valid   = av;
    alu_rob_id  = a_id;
    alu_value   = a_val;
    alu_jump    = a_jmp;
    alu_pc_next = a_pc;
    lsb_valid   = lv;
    lsb_rob_id  = l_id;
    lsb_value   = l_val;
    acc_a = av && rdy && (aq.size() < DEPTH);
    acc_l = lv && rdy && (lq.size() < DEPTH);
    @(posedge clk);
    #1;
    if (rdy && mispredict) begin
      aq.delete();
      lq.delete();
      e_valid = 1'b0;
      m_last  = 1'b1;
    end else if (rdy) begin
      if (acc_a) aq.push_back(ea);
      if (acc_l) lq.push_back(el);
      ga = (aq.size() > 0) && ((lq.size() == 0) || m_last);
      gl = (lq.size() > 0) && !ga;
      if (ga) begin
        e = aq.pop_front();
        e_valid = 1'b1; e_id = e.id; e_val = e.val; e_jmp = e.jmp; e_pc = e.pc;
        e_src = 1'b0; m_last = 1'b0;
      end else if (gl) begin
        e = lq.pop_front();
        e_valid = 1'b1; e_id = e.id; e_val = e.val; e_jmp = 1'b0; e_pc = '0;
        e_src = 1'b1; m_last = 1'b1;
      end else begin
        e_valid = 1'b0;
      end
    end
    check_outputs();
    if (acc_a) begin
      a_id  = a_id + 1'b1;
      a_val = a_val + 32'h11;
      a_jmp = ~a_jmp;
      a_pc  = a_pc + 32'd4;
    end
    if (acc_l) begin
      l_id  = l_id + 1'b1;
      l_val = l_val + 32'h101;
    end
  endtask

  initial begin
    // Reset state, sampled while reset is held between edges
    #2;
    model_reset();
    check_outputs();
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Single ALU result bypasses straight onto the bus
    a_id = 4'd3; a_val = 32'h1234_5678; a_jmp = 1'b1; a_pc = 32'h100;
    step(1'b1, 1'b0);
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_id", 64'(cdb_rob_id), 64'd3);
    chk("t1_value", 64'(cdb_value), 64'h1234_5678);
    chk("t1_jump", 64'(cdb_jump), 64'd1);
    chk("t1_pc", 64'(cdb_pc_next), 64'h100);
    chk("t1_src", 64'(cdb_src), 64'd0);
    chk("t1_alu_count", 64'(alu_count), 64'd0);
    step(1'b0, 1'b0);
    chk("t1_pulse_end", 64'(cdb_valid), 64'd0);
    chk("t1_alu_count2", 64'(alu_count), 64'd0);

    // Flush restores the ALU-first tie, then both offer in the same cycle
    mispredict = 1'b1;
    step(1'b0, 1'b0);
    mispredict = 1'b0;
    a_id = 4'd1; l_id = 4'd2;
    step(1'b1, 1'b1);
    chk("t2_id_a", 64'(cdb_rob_id), 64'd1);
    chk("t2_src_a", 64'(cdb_src), 64'd0);
    chk("t2_lsbcnt_a", 64'(lsb_count), 64'd1);
    step(1'b0, 1'b0);
    chk("t2_id_b", 64'(cdb_rob_id), 64'd2);
    chk("t2_src_b", 64'(cdb_src), 64'd1);
    chk("t2_lsbcnt_b", 64'(lsb_count), 64'd0);
    step(1'b0, 1'b0);

    // Saturation: both sources every cycle, grants alternate starting with ALU
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      chk("t3_valid", 64'(cdb_valid), 64'd1);
      chk("t3_alternate", 64'(cdb_src), 64'(i % 2));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // Fill both FIFOs to three, then flush with fresh inputs offered
    mispredict = 1'b1;
    step(1'b0, 1'b0);
    mispredict = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    chk("t4_alu_fill", 64'(alu_count), 64'd3);
    chk("t4_lsb_fill", 64'(lsb_count), 64'd3);
    mispredict = 1'b1;
    step(1'b1, 1'b1);
    mispredict = 1'b0;
    chk("t4_valid", 64'(cdb_valid), 64'd0);
    chk("t4_alu_cnt", 64'(alu_count), 64'd0);
    chk("t4_lsb_cnt", 64'(lsb_count), 64'd0);
    chk("t4_alu_rdy", 64'(alu_ready), 64'd1);
    chk("t4_lsb_rdy", 64'(lsb_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("t4_no_flushed", 64'(cdb_valid), 64'd0);
    end

    // Two LSB entries queued, then rdy low for three cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("t5_lsb_queued", 64'(lsb_count), 64'd2);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk("t5_frozen_lsb", 64'(lsb_count), 64'd2);
      chk("t5_alu_rdy0", 64'(alu_ready), 64'd0);
      chk("t5_lsb_rdy0", 64'(lsb_ready), 64'd0);
    end
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    // Asynchronous reset between edges with entries queued
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("t6_valid", 64'(cdb_valid), 64'd0);
    chk("t6_alu_cnt", 64'(alu_count), 64'd0);
    chk("t6_lsb_cnt", 64'(lsb_count), 64'd0);
    model_reset();
    check_outputs();
    #2 rst = 1'b1;
    a_id = 4'd9; l_id = 4'd10;
    step(1'b1, 1'b1);
    chk("t6_tie_src", 64'(cdb_src), 64'd0);
    chk("t6_tie_id", 64'(cdb_rob_id), 64'd9);
    step(1'b0, 1'b0);
    chk("t6_second_id", 64'(cdb_rob_id), 64'd10);
    step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
